cpu_control_unit: RTL and testbench
===================================

// Module: cpu_control_unit
// PURPOSE
//  Multi-cycle sequencer that drives the CPU_DataPath control inputs.
//  Consumes opcode and the ALU flags (C,V,S,Z_det) and produces every ld*/rd*/wr*/fsel strobe.
//  Fixed 5-state cycle: FETCH->DECODE->EXEC->MEM->WB. Stops in HALT on the halt opcode.
// PARAMETERS
//  OPW      5        opcode width
//  FSELW    3        ALU function-select width
//  HALT_OP  5'h1F    opcode that enters HALT
// PORTS
//  clk      in   1  clock; all state updates on posedge
//  rst      in   1  synchronous, active-high reset
//  opcode   in   5  datapath instruction opcode field
//  C,V,S,Z_det in 1 each  ALU flags from the datapath
//  ldPC2,ldPCz,ldXr1,ldXr2,ldXPC,ldYr1,ldYr2,alu_ld  out 1 each  datapath strobes
//  ldRPC,ldRZ,ldRM,rdr1,rdr2,rdm,wrm                 out 1 each  datapath strobes
//  ldOff11to16,ldOff8to16,ldOff5to16                 out 1 each  offset-select strobes
//  fsel     out  3  ALU function: 000 add,001 sub,010 and,011 or,100 neg,101 sub,110 passX,111 passY
//  halt     out  1  sticky; high while in HALT
//  illegal  out  1  1-cycle pulse in WB of an undefined opcode
//  instr_done out 1 1-cycle pulse in WB of every instruction except HALT
// BEHAVIOUR
//  - All outputs are registered Moore outputs decoded from next state plus latched op.
//  - rst: state=FETCH, op=0, flags=0, every output 0 (fsel=000), including halt.
//  - FETCH: all strobes 0; instruction memory updates on the negedge.
//  - DECODE: latch opcode into op; assert rdr1/rdr2 for the operands the instruction uses.
//  - EXEC: keep rdr*; assert one X select, one Y/offset select, fsel, alu_ld.
//    X selects and Y selects are each one-hot or all-zero.
//  - MEM: LD asserts rdm; ST asserts wrm plus rdr1. Each is exactly one cycle.
//    For flag-setting ops (ADD,SUB,AND,OR,NEG,CMPR,ADDI) latch {C,V,S,Z_det} into the flag register.
//  - WB: assert the reg-write strobe (ldRZ/ldRM/ldRPC). Assert exactly one of ldPC2/ldPCz.
//    Never both ldPC2 and ldPCz. Never more than one of ldRPC/ldRZ/ldRM. Then return to FETCH.
//  - Latency: 5 cycles per instruction. Branch targets are relative to the address of the branch itself.
//  - Opcode map (r1=ropd1, r2=ropd2):
//    00000-00011  ADD/SUB/AND/OR r1=r1 op r2   X=r1 Y=r2 ldRZ
//    00100        NEG  r1=-r1                  X=r1 fsel 100 ldRZ
//    00101        CMPR flags(r1-r2)            no reg write
//    00110        ADDI r1=r1+sext5             Y=Off5
//    00111        LDI  r1=sext8                Y=Off8 fsel 111
//    01000        LD   r1=M[r2+sext5]          X=r2 Y=Off5 rdm ldRM
//    01001        ST   M[r2+sext5]=r1          wrm
//    01010        BR   PC=PC+sext11            X=PC Y=Off11 ldPCz
//    01011-01111  BZ,BNZ,BN,BC,BV              ldPCz if latched flag condition true, else ldPC2
//    10000        JAL  r1=PC, PC=PC+sext8      ldRPC and ldPCz in the same WB
//    10001        JR   PC=r1                   X=r1 fsel 110 ldPCz
//    11111        HALT                         no strobes; halt=1 until rst
//    other        NOP: WB ldPC2 only, illegal=1
//  - Branches with no prior flag-setting op use the reset flags (all 0).
//  - rst in any state, including mid-instruction: no pending strobe is issued on the next cycle.
// STRUCTURE
//  - cpu_ctrl_defs.vh: opcode localparams, state encodings (3-bit), fsel codes, control-word bit indices.
//  - Sub-module ctrl_decode: combinational (op, state, flags) -> control word.
//    Top file holds the state register, op/flag registers and the output register.
// TESTING
//  - rst high 2 cycles -> all outputs 0. Release with op=ADD -> first ldPC2 at cycle 5 after release, instr_done with it.
//  - ADD (00000) -> DECODE rdr1=rdr2=1. EXEC ldXr1,ldYr2,alu_ld,fsel=000. WB ldRZ,ldPC2 only.
//  - CMPR with Z_det=1 then BZ -> WB ldPCz=1,ldPC2=0, EXEC ldXPC,ldOff11to16. Same with BNZ -> ldPC2=1.
//  - LD -> MEM rdm=1 one cycle, WB ldRM. ST -> MEM wrm=1 exactly one cycle, no ldR* in WB.
//  - opcode 11111 -> halt=1 sticky, zero strobes for 20 cycles; rst clears it. opcode 10101 -> illegal pulse, ldPC2 only.
//  - rst asserted during EXEC of ADD -> next cycle all outputs 0, no ldRZ, flags cleared, restarts at FETCH.

Source files
------------

// File: rtl/cpu_control_unit_pkg.sv
// Shared definitions for the CPU control unit.
// Contents: opcode map, ALU function-select codes, sequencer state encoding,
// the latched flag register layout and the control word that the decoder
// produces and the top-level registers onto its output ports.
package cpu_control_unit_pkg;

    localparam int OPW   = 5;
    localparam int FSELW = 3;

    localparam logic [OPW-1:0] HALT_OP = 5'h1F;

    localparam logic [OPW-1:0] OP_ADD  = 5'h00;
    localparam logic [OPW-1:0] OP_SUB  = 5'h01;
    localparam logic [OPW-1:0] OP_AND  = 5'h02;
    localparam logic [OPW-1:0] OP_OR   = 5'h03;
    localparam logic [OPW-1:0] OP_NEG  = 5'h04;
    localparam logic [OPW-1:0] OP_CMPR = 5'h05;
    localparam logic [OPW-1:0] OP_ADDI = 5'h06;
    localparam logic [OPW-1:0] OP_LDI  = 5'h07;
    localparam logic [OPW-1:0] OP_LD   = 5'h08;
    localparam logic [OPW-1:0] OP_ST   = 5'h09;
    localparam logic [OPW-1:0] OP_BR   = 5'h0A;
    localparam logic [OPW-1:0] OP_BZ   = 5'h0B;
    localparam logic [OPW-1:0] OP_BNZ  = 5'h0C;
    localparam logic [OPW-1:0] OP_BN   = 5'h0D;
    localparam logic [OPW-1:0] OP_BC   = 5'h0E;
    localparam logic [OPW-1:0] OP_BV   = 5'h0F;
    localparam logic [OPW-1:0] OP_JAL  = 5'h10;
    localparam logic [OPW-1:0] OP_JR   = 5'h11;

    localparam logic [FSELW-1:0] FSEL_ADD   = 3'b000;
    localparam logic [FSELW-1:0] FSEL_SUB   = 3'b001;
    localparam logic [FSELW-1:0] FSEL_AND   = 3'b010;
    localparam logic [FSELW-1:0] FSEL_OR    = 3'b011;
    localparam logic [FSELW-1:0] FSEL_NEG   = 3'b100;
    localparam logic [FSELW-1:0] FSEL_PASSX = 3'b110;
    localparam logic [FSELW-1:0] FSEL_PASSY = 3'b111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef struct packed {
        logic c;
        logic v;
        logic s;
        logic z;
    } flags_t;

    typedef struct packed {
        logic             ld_pc2;
        logic             ld_pcz;
        logic             ld_xr1;
        logic             ld_xr2;
        logic             ld_xpc;
        logic             ld_yr1;
        logic             ld_yr2;
        logic             alu_ld;
        logic             ld_rpc;
        logic             ld_rz;
        logic             ld_rm;
        logic             rdr1;
        logic             rdr2;
        logic             rdm;
        logic             wrm;
        logic             ld_off11;
        logic             ld_off8;
        logic             ld_off5;
        logic [FSELW-1:0] fsel;
        logic             halt;
        logic             illegal;
        logic             instr_done;
    } ctrl_t;

    // Defined instructions, excluding HALT (which never reaches EXEC/WB).
    function automatic logic op_is_legal(input logic [OPW-1:0] op);
        return op <= OP_JR;
    endfunction

    // ALU ops whose MEM cycle captures the datapath flags.
    function automatic logic op_sets_flags(input logic [OPW-1:0] op);
        return op <= OP_ADDI;
    endfunction

endpackage

// File: rtl/cpu_control_unit_decode.sv
// Combinational control-word decoder.
// Inputs : state - sequencer state the outputs are being produced for
//          op    - instruction opcode valid for that state
//          flags - latched {C,V,S,Z} used by conditional branches
// Output : ctrl  - full control word (strobes, fsel, status pulses)
module cpu_control_unit_decode
    import cpu_control_unit_pkg::*;
(
    input  state_t         state,
    input  logic [OPW-1:0] op,
    input  flags_t         flags,
    output ctrl_t          ctrl
);

    logic uses_r1;
    logic uses_r2;
    logic taken;

    // Register-file operands each instruction reads (ST needs r2 for the
    // address and r1 for the store data).
    always_comb begin
        uses_r1 = 1'b0;
        uses_r2 = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_CMPR, OP_ST: begin
                uses_r1 = 1'b1;
                uses_r2 = 1'b1;
            end
            OP_NEG, OP_ADDI, OP_JR: uses_r1 = 1'b1;
            OP_LD:                  uses_r2 = 1'b1;
            default: ;
        endcase
    end

    // PC redirect decision for WB; everything else falls through to PC+2.
    always_comb begin
        taken = 1'b0;
        case (op)
            OP_BR, OP_JAL, OP_JR: taken = 1'b1;
            OP_BZ:                taken = flags.z;
            OP_BNZ:               taken = ~flags.z;
            OP_BN:                taken = flags.s;
            OP_BC:                taken = flags.c;
            OP_BV:                taken = flags.v;
            default:              taken = 1'b0;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state)
            ST_DECODE: begin
                ctrl.rdr1 = uses_r1;
                ctrl.rdr2 = uses_r2;
            end
            ST_EXEC: begin
                if (op_is_legal(op)) begin
                    ctrl.rdr1   = uses_r1;
                    ctrl.rdr2   = uses_r2;
                    ctrl.alu_ld = 1'b1;
                    case (op)
                        OP_ADD: begin
                            ctrl.ld_xr1 = 1'b1;
                            ctrl.ld_yr2 = 1'b1;
                            ctrl.fsel   = FSEL_ADD;
                        end
                        OP_SUB, OP_CMPR: begin
                            ctrl.ld_xr1 = 1'b1;
                            ctrl.ld_yr2 = 1'b1;
                            ctrl.fsel   = FSEL_SUB;
                        end
                        OP_AND: begin
                            ctrl.ld_xr1 = 1'b1;
                            ctrl.ld_yr2 = 1'b1;
                            ctrl.fsel   = FSEL_AND;
                        end
                        OP_OR: begin
                            ctrl.ld_xr1 = 1'b1;
                            ctrl.ld_yr2 = 1'b1;
                            ctrl.fsel   = FSEL_OR;
                        end
                        OP_NEG: begin
                            ctrl.ld_xr1 = 1'b1;
                            ctrl.fsel   = FSEL_NEG;
                        end
                        OP_ADDI: begin
                            ctrl.ld_xr1  = 1'b1;
                            ctrl.ld_off5 = 1'b1;
                            ctrl.fsel    = FSEL_ADD;
                        end
                        OP_LDI: begin
                            ctrl.ld_off8 = 1'b1;
                            ctrl.fsel    = FSEL_PASSY;
                        end
                        OP_LD, OP_ST: begin
                            ctrl.ld_xr2  = 1'b1;
                            ctrl.ld_off5 = 1'b1;
                            ctrl.fsel    = FSEL_ADD;
                        end
                        // PC still holds the branch's own address here.
                        OP_BR, OP_BZ, OP_BNZ, OP_BN, OP_BC, OP_BV: begin
                            ctrl.ld_xpc   = 1'b1;
                            ctrl.ld_off11 = 1'b1;
                            ctrl.fsel     = FSEL_ADD;
                        end
                        OP_JAL: begin
                            ctrl.ld_xpc  = 1'b1;
                            ctrl.ld_off8 = 1'b1;
                            ctrl.fsel    = FSEL_ADD;
                        end
                        OP_JR: begin
                            ctrl.ld_xr1 = 1'b1;
                            ctrl.fsel   = FSEL_PASSX;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MEM: begin
                ctrl.rdm  = (op == OP_LD);
                ctrl.wrm  = (op == OP_ST);
                ctrl.rdr1 = (op == OP_ST);
            end
            ST_WB: begin
                ctrl.instr_done = 1'b1;
                ctrl.illegal    = ~op_is_legal(op);
                ctrl.ld_rz      = (op <= OP_NEG) || (op == OP_ADDI) || (op == OP_LDI);
                ctrl.ld_rm      = (op == OP_LD);
                ctrl.ld_rpc     = (op == OP_JAL);
                ctrl.ld_pcz     = taken;
                ctrl.ld_pc2     = ~taken;
            end
            ST_HALT: ctrl.halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle control sequencer for the CPU datapath.
// Runs FETCH->DECODE->EXEC->MEM->WB per instruction and parks in HALT on
// the halt opcode until reset.
// Ports: clk/rst (sync, active-high), opcode and ALU flags C,V,S,Z_det in;
// datapath load/read/write strobes, offset selects, fsel, halt, illegal and
// instr_done out. Every output is a flop, decoded from the next state so
// it is valid for the whole cycle of the state it belongs to.
module cpu_control_unit
    import cpu_control_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [OPW-1:0]   opcode,
    input  logic             C,
    input  logic             V,
    input  logic             S,
    input  logic             Z_det,
    output logic             ldPC2,
    output logic             ldPCz,
    output logic             ldXr1,
    output logic             ldXr2,
    output logic             ldXPC,
    output logic             ldYr1,
    output logic             ldYr2,
    output logic             alu_ld,
    output logic             ldRPC,
    output logic             ldRZ,
    output logic             ldRM,
    output logic             rdr1,
    output logic             rdr2,
    output logic             rdm,
    output logic             wrm,
    output logic             ldOff11to16,
    output logic             ldOff8to16,
    output logic             ldOff5to16,
    output logic [FSELW-1:0] fsel,
    output logic             halt,
    output logic             illegal,
    output logic             instr_done
);

    state_t         state_q, state_d;
    logic [OPW-1:0] op_q, op_d;
    flags_t         flags_q, flags_d;
    ctrl_t          ctrl_q, ctrl_d;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        flags_d = flags_q;
        case (state_q)
            ST_FETCH: begin
                state_d = ST_DECODE;
                op_d    = opcode;
            end
            ST_DECODE: state_d = (op_q == HALT_OP) ? ST_HALT : ST_EXEC;
            ST_EXEC:   state_d = ST_MEM;
            ST_MEM: begin
                state_d = ST_WB;
                // ALU result register was loaded at the end of EXEC, so the
                // flags presented during MEM belong to this instruction.
                if (op_sets_flags(op_q)) begin
                    flags_d = {C, V, S, Z_det};
                end
            end
            ST_WB:     state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_FETCH;
        endcase
    end

    // Decode against next-cycle values so the registered word lines up with
    // the state it describes.
    cpu_control_unit_decode u_decode (
        .state (state_d),
        .op    (op_d),
        .flags (flags_d),
        .ctrl  (ctrl_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            op_q    <= '0;
            flags_q <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            flags_q <= flags_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign ldPC2       = ctrl_q.ld_pc2;
    assign ldPCz       = ctrl_q.ld_pcz;
    assign ldXr1       = ctrl_q.ld_xr1;
    assign ldXr2       = ctrl_q.ld_xr2;
    assign ldXPC       = ctrl_q.ld_xpc;
    assign ldYr1       = ctrl_q.ld_yr1;
    assign ldYr2       = ctrl_q.ld_yr2;
    assign alu_ld      = ctrl_q.alu_ld;
    assign ldRPC       = ctrl_q.ld_rpc;
    assign ldRZ        = ctrl_q.ld_rz;
    assign ldRM        = ctrl_q.ld_rm;
    assign rdr1        = ctrl_q.rdr1;
    assign rdr2        = ctrl_q.rdr2;
    assign rdm         = ctrl_q.rdm;
    assign wrm         = ctrl_q.wrm;
    assign ldOff11to16 = ctrl_q.ld_off11;
    assign ldOff8to16  = ctrl_q.ld_off8;
    assign ldOff5to16  = ctrl_q.ld_off5;
    assign fsel        = ctrl_q.fsel;
    assign halt        = ctrl_q.halt;
    assign illegal     = ctrl_q.illegal;
    assign instr_done  = ctrl_q.instr_done;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: directed instruction sequence, a table-driven
// reference model compared every cycle, and literal spot checks.
module tb_cpu_control_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] opcode = 5'd0;
    logic       C = 1'b0, V = 1'b0, S = 1'b0, Z_det = 1'b0;
    logic ldPC2, ldPCz, ldXr1, ldXr2, ldXPC, ldYr1, ldYr2, alu_ld;
    logic ldRPC, ldRZ, ldRM, rdr1, rdr2, rdm, wrm;
    logic ldOff11to16, ldOff8to16, ldOff5to16;
    logic [2:0] fsel;
    logic halt, illegal, instr_done;

    cpu_control_unit dut (
        .clk(clk), .rst(rst), .opcode(opcode),
        .C(C), .V(V), .S(S), .Z_det(Z_det),
        .ldPC2(ldPC2), .ldPCz(ldPCz), .ldXr1(ldXr1), .ldXr2(ldXr2),
        .ldXPC(ldXPC), .ldYr1(ldYr1), .ldYr2(ldYr2), .alu_ld(alu_ld),
        .ldRPC(ldRPC), .ldRZ(ldRZ), .ldRM(ldRM), .rdr1(rdr1), .rdr2(rdr2),
        .rdm(rdm), .wrm(wrm), .ldOff11to16(ldOff11to16),
        .ldOff8to16(ldOff8to16), .ldOff5to16(ldOff5to16), .fsel(fsel),
        .halt(halt), .illegal(illegal), .instr_done(instr_done)
    );

    always #5 clk = ~clk;

    // Bench-side packing of every output, bit 0 = ldPC2 ... bit 23 = instr_done.
    localparam logic [23:0] M_PC2  = 24'd1 << 0;
    localparam logic [23:0] M_PCZ  = 24'd1 << 1;
    localparam logic [23:0] M_XR1  = 24'd1 << 2;
    localparam logic [23:0] M_XR2  = 24'd1 << 3;
    localparam logic [23:0] M_XPC  = 24'd1 << 4;
    localparam logic [23:0] M_YR2  = 24'd1 << 6;
    localparam logic [23:0] M_ALU  = 24'd1 << 7;
    localparam logic [23:0] M_RPC  = 24'd1 << 8;
    localparam logic [23:0] M_RZ   = 24'd1 << 9;
    localparam logic [23:0] M_RM   = 24'd1 << 10;
    localparam logic [23:0] M_RDR1 = 24'd1 << 11;
    localparam logic [23:0] M_RDR2 = 24'd1 << 12;
    localparam logic [23:0] M_RDM  = 24'd1 << 13;
    localparam logic [23:0] M_WRM  = 24'd1 << 14;
    localparam logic [23:0] M_O11  = 24'd1 << 15;
    localparam logic [23:0] M_O8   = 24'd1 << 16;
    localparam logic [23:0] M_O5   = 24'd1 << 17;
    localparam logic [23:0] M_HALT = 24'd1 << 21;
    localparam logic [23:0] M_ILL  = 24'd1 << 22;
    localparam logic [23:0] M_DONE = 24'd1 << 23;

    logic [23:0] dut_vec;
    assign dut_vec = {instr_done, illegal, halt, fsel, ldOff5to16, ldOff8to16,
                      ldOff11to16, wrm, rdm, rdr2, rdr1, ldRM, ldRZ, ldRPC,
                      alu_ld, ldYr2, ldYr1, ldXPC, ldXr2, ldXr1, ldPCz, ldPC2};

    int          total = 0;
    int          bad   = 0;
    logic [23:0] exp_vec = '0;
    logic        chk_en  = 1'b0;
    logic [4:0]  cur_op  = '0;
    int          cur_ph  = 0;
    logic [3:0]  m_flags = '0;   // {C,V,S,Z} as the model believes they are latched
    logic [23:0] obs [5];

    // Reference model: per-opcode instruction description, then which part of
    // it shows up in each phase (0 FETCH .. 4 WB). Phases >= 2 of HALT are halt-only.
    function automatic logic [23:0] model(input logic [4:0] op, input int ph,
                                          input logic [3:0] fl);
        logic [23:0] v, xm, ym, dm, rd;
        logic [2:0]  f;
        bit r1, r2, legal, jump, is_halt;
        v = '0; xm = '0; ym = '0; dm = '0; f = 3'b000;
        r1 = 0; r2 = 0; legal = 1; jump = 0; is_halt = 0;
        case (op)
            5'h00, 5'h01, 5'h02, 5'h03: begin
                r1 = 1; r2 = 1; xm = M_XR1; ym = M_YR2; f = op[2:0]; dm = M_RZ;
            end
            5'h04: begin r1 = 1; xm = M_XR1; f = 3'b100; dm = M_RZ; end
            5'h05: begin r1 = 1; r2 = 1; xm = M_XR1; ym = M_YR2; f = 3'b001; end
            5'h06: begin r1 = 1; xm = M_XR1; ym = M_O5; dm = M_RZ; end
            5'h07: begin ym = M_O8; f = 3'b111; dm = M_RZ; end
            5'h08: begin r2 = 1; xm = M_XR2; ym = M_O5; dm = M_RM; end
            5'h09: begin r1 = 1; r2 = 1; xm = M_XR2; ym = M_O5; end
            5'h0A: begin xm = M_XPC; ym = M_O11; jump = 1; end
            5'h0B: begin xm = M_XPC; ym = M_O11; jump = fl[0]; end
            5'h0C: begin xm = M_XPC; ym = M_O11; jump = !fl[0]; end
            5'h0D: begin xm = M_XPC; ym = M_O11; jump = fl[1]; end
            5'h0E: begin xm = M_XPC; ym = M_O11; jump = fl[3]; end
            5'h0F: begin xm = M_XPC; ym = M_O11; jump = fl[2]; end
            5'h10: begin xm = M_XPC; ym = M_O8; dm = M_RPC; jump = 1; end
            5'h11: begin r1 = 1; xm = M_XR1; f = 3'b110; jump = 1; end
            5'h1F: is_halt = 1;
            default: legal = 0;
        endcase
        rd = (r1 ? M_RDR1 : 24'd0) | (r2 ? M_RDR2 : 24'd0);
        if (is_halt) begin
            v = (ph >= 2) ? M_HALT : 24'd0;
        end else begin
            case (ph)
                1: v = rd;
                2: if (legal) v = rd | xm | ym | M_ALU | ({21'd0, f} << 18);
                3: begin
                    if (op == 5'h08) v = M_RDM;
                    else if (op == 5'h09) v = M_WRM | M_RDR1;
                end
                4: v = dm | (jump ? M_PCZ : M_PC2) | M_DONE | (legal ? 24'd0 : M_ILL);
                default: v = '0;
            endcase
        end
        return v;
    endfunction

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            total++;
            if (dut_vec !== exp_vec) begin
                bad++;
                $display("FAIL cycle_check op=%b ph=%0d got=%h want=%h",
                         cur_op, cur_ph, dut_vec, exp_vec);
            end
        end
    end

    task automatic check(input string name, input logic [23:0] got, input logic [23:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Enter just after the edge that starts FETCH; leave just after the
    // edge that starts the next FETCH.
    task automatic run_instr(input logic [4:0] op, input logic [3:0] fl_in);
        cur_op = op;
        opcode = op;
        {C, V, S, Z_det} = fl_in;
        for (int ph = 0; ph < 5; ph++) begin
            cur_ph = ph;
            if (ph == 4 && op <= 5'h06) m_flags = fl_in;
            exp_vec = model(op, ph, m_flags);
            @(negedge clk);
            obs[ph] = dut_vec;
            @(posedge clk);
            #1;
        end
        $display("instr op=%b flags=%b exec=%h mem=%h wb=%h", op, m_flags, obs[2], obs[3], obs[4]);
    endtask

    task automatic do_reset(input int n);
        chk_en = 1'b0;
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        m_flags = '0;
        exp_vec = '0;
        cur_ph = 0;
        chk_en = 1'b1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int first_pc2;
        int hcnt;
        do_reset(2);

        // First instruction after reset: ADD.
        run_instr(5'h00, 4'b0000);
        check("reset_outputs_zero", obs[0], 24'd0);
        check("add_decode", obs[1], M_RDR1 | M_RDR2);
        check("add_exec", obs[2], M_RDR1 | M_RDR2 | M_XR1 | M_YR2 | M_ALU);
        check("add_wb", obs[4], M_RZ | M_PC2 | M_DONE);
        first_pc2 = 0;
        for (int i = 4; i >= 0; i--) if (obs[i][0]) first_pc2 = i + 1;
        check("first_pc2_cycle", 24'(first_pc2), 24'd5);

        run_instr(5'h01, 4'b0000);
        run_instr(5'h02, 4'b0000);
        run_instr(5'h03, 4'b0000);
        run_instr(5'h04, 4'b0000);

        // CMPR sets Z, then BZ taken / BNZ not taken.
        run_instr(5'h05, 4'b0001);
        run_instr(5'h0B, 4'b0000);
        check("bz_exec", obs[2], M_XPC | M_O11 | M_ALU);
        check("bz_taken_wb", obs[4], M_PCZ | M_DONE);
        run_instr(5'h05, 4'b0001);
        run_instr(5'h0C, 4'b0000);
        check("bnz_not_taken_wb", obs[4], M_PC2 | M_DONE);

        // ADDI latches C and S; BN and BC taken, BV not.
        run_instr(5'h06, 4'b1010);
        run_instr(5'h0D, 4'b0000);
        run_instr(5'h0E, 4'b0000);
        check("bc_taken_wb", obs[4], M_PCZ | M_DONE);
        run_instr(5'h0F, 4'b0000);
        check("bv_not_taken_wb", obs[4], M_PC2 | M_DONE);

        run_instr(5'h07, 4'b0000);
        run_instr(5'h08, 4'b0000);
        check("ld_mem", obs[3], M_RDM);
        check("ld_wb", obs[4], M_RM | M_PC2 | M_DONE);
        run_instr(5'h09, 4'b0000);
        check("st_mem", obs[3], M_WRM | M_RDR1);
        check("st_wb", obs[4], M_PC2 | M_DONE);
        run_instr(5'h0A, 4'b0000);
        run_instr(5'h10, 4'b0000);
        check("jal_wb", obs[4], M_RPC | M_PCZ | M_DONE);
        run_instr(5'h11, 4'b0000);
        check("jr_exec", obs[2], M_RDR1 | M_XR1 | M_ALU | (24'd6 << 18));
        run_instr(5'h15, 4'b0000);
        check("illegal_wb", obs[4], M_PC2 | M_ILL | M_DONE);
        run_instr(5'h12, 4'b0000);

        // Reset during EXEC of ADD after CMPR left Z=1 latched.
        run_instr(5'h05, 4'b0001);
        cur_op = 5'h00;
        opcode = 5'h00;
        {C, V, S, Z_det} = 4'b1001;
        for (int ph = 0; ph < 3; ph++) begin
            cur_ph = ph;
            exp_vec = model(5'h00, ph, m_flags);
            @(negedge clk);
            if (ph == 2) rst = 1'b1;
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        m_flags = '0;
        exp_vec = '0;
        $display("instr op=00000 aborted by reset in exec");
        run_instr(5'h0B, 4'b0000);
        check("rst_mid_exec_outputs", obs[0], 24'd0);
        check("rst_clears_flags_bz", obs[4], M_PC2 | M_DONE);

        // HALT: sticky for 20 cycles, cleared only by reset.
        cur_op = 5'h1F;
        opcode = 5'h1F;
        {C, V, S, Z_det} = 4'b0000;
        hcnt = 0;
        for (int ph = 0; ph < 22; ph++) begin
            cur_ph = ph;
            exp_vec = model(5'h1F, ph, m_flags);
            @(negedge clk);
            if (ph >= 2 && dut_vec === M_HALT) hcnt++;
            @(posedge clk);
            #1;
        end
        check("halt_sticky_cycles", 24'(hcnt), 24'd20);
        $display("instr op=11111 halt cycles=%0d", hcnt);
        do_reset(1);
        run_instr(5'h00, 4'b0000);
        check("halt_cleared_by_rst", obs[0], 24'd0);
        check("restart_add_wb", obs[4], M_RZ | M_PC2 | M_DONE);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
